// File: rtl/logic_unit_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : logic_unit_p                                                  |
// | Purpose  : Bitwise logic op unit with zero flag and a HOLD-cycle busy    |
// |            flag that blocks new opcodes while it is high.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module logic_unit_p #(
    parameter int               WIDTH   = 8,
    parameter int               OPW     = 4,
    parameter int               HOLD    = 3,
    parameter logic [OPW-1:0]   OP_AND  = OPW'(4'b1110),
    parameter logic [OPW-1:0]   OP_OR   = OPW'(4'b1101),
    parameter logic [OPW-1:0]   OP_XOR  = OPW'(4'b1100),
    parameter logic [OPW-1:0]   OP_NOT  = OPW'(4'b1011),
    parameter logic [OPW-1:0]   OP_NAND = OPW'(4'b1010),
    parameter logic [OPW-1:0]   OP_NOR  = OPW'(4'b1001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   ctr1,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ctr
);

    localparam int            C_CW       = $clog2(HOLD + 1);
    localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(HOLD - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [C_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_out, w_out_nxt;
    logic              r_zero, w_zero_nxt;
    logic              w_hit;
    logic [WIDTH-1:0]  w_result;

    // Priority chain resolves colliding opcode parameters: AND first, NOR last.
    always_comb begin
        w_hit    = 1'b1;
        w_result = '0;
        if (ctr1 == OP_AND)       w_result = data1 & data2;
        else if (ctr1 == OP_OR)   w_result = data1 | data2;
        else if (ctr1 == OP_XOR)  w_result = data1 ^ data2;
        else if (ctr1 == OP_NOT)  w_result = ~data1;
        else if (ctr1 == OP_NAND) w_result = ~(data1 & data2);
        else if (ctr1 == OP_NOR)  w_result = ~(data1 | data2);
        else                      w_hit    = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_zero_nxt  = r_zero;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_out_nxt   = w_result;
                    w_zero_nxt  = (w_result == '0);
                    w_cnt_nxt   = C_CNT_LOAD;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Inputs are ignored here; the counter alone sets the hold length.
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    assign out  = r_out;
    assign zero = r_zero;
    assign ctr  = (r_state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_logic_unit_p                                               |
// | Purpose  : Self-checking bench for logic_unit_p (8-bit/HOLD=3 and        |
// |            16-bit/HOLD=1 instances) against a behavioural model.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_logic_unit_p;

    localparam logic [3:0] OP_AND  = 4'b1110;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam int         HOLD8   = 3;
    localparam int         HOLD16  = 1;

    logic        clk = 1'b0;
    logic        rst8, rst16;
    logic [3:0]  op8, op16;
    logic [7:0]  a8, b8, out8;
    logic [15:0] a16, b16, out16;
    logic        zero8, ctr8, zero16, ctr16;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  m8_out;
    logic        m8_zero;
    int          m8_busy;
    logic [15:0] m16_out;
    logic        m16_zero;
    int          m16_busy;

    logic [3:0] ops [6] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR};

    always #5 clk = ~clk;

    logic_unit_p u_dut8 (
        .clk(clk), .rst(rst8), .ctr1(op8), .data1(a8), .data2(b8),
        .out(out8), .zero(zero8), .ctr(ctr8)
    );

    logic_unit_p #(.WIDTH(16), .HOLD(HOLD16)) u_dut16 (
        .clk(clk), .rst(rst16), .ctr1(op16), .data1(a16), .data2(b16),
        .out(out16), .zero(zero16), .ctr(ctr16)
    );

    // Returns {accepted, result masked to w bits}.
    function automatic logic [16:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input int w);
        logic [15:0] mask;
        logic [15:0] r;
        logic        v;
        mask = 16'hFFFF >> (16 - w);
        v    = 1'b1;
        r    = 16'h0;
        if (op == OP_AND)       r = a & b;
        else if (op == OP_OR)   r = a | b;
        else if (op == OP_XOR)  r = a ^ b;
        else if (op == OP_NOT)  r = ~a;
        else if (op == OP_NAND) r = ~(a & b);
        else if (op == OP_NOR)  r = ~(a | b);
        else                    v = 1'b0;
        return {v, r & mask};
    endfunction

    // One clock edge: the model sees the same inputs the DUTs sample.
    task automatic tick();
        logic [16:0] r;
        @(posedge clk);
        if (rst8) begin
            m8_out = '0; m8_zero = 1'b0; m8_busy = 0;
        end else if (m8_busy > 0) begin
            m8_busy--;
        end else begin
            r = ref_op(op8, {8'h00, a8}, {8'h00, b8}, 8);
            if (r[16]) begin
                m8_out = r[7:0]; m8_zero = (r[7:0] == 8'h00); m8_busy = HOLD8;
            end
        end
        if (rst16) begin
            m16_out = '0; m16_zero = 1'b0; m16_busy = 0;
        end else if (m16_busy > 0) begin
            m16_busy--;
        end else begin
            r = ref_op(op16, a16, b16, 16);
            if (r[16]) begin
                m16_out = r[15:0]; m16_zero = (r[15:0] == 16'h0); m16_busy = HOLD16;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst16 = 1'b1; op8 = 4'h0; op16 = 4'h0;
        a8 = 8'hFF; b8 = 8'hFF; a16 = '0; b16 = '0;
        tick(); tick();
        n_cmp++; if (out8 !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out8); end
        n_cmp++; if (zero8 !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero8); end
        n_cmp++; if (ctr8 !== 1'b0) begin n_err++; $display("FAIL reset_ctr: got %b want 0", ctr8); end
        rst8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (ctr8 !== 1'b0) begin n_err++; $display("FAIL idle_ctr[%0d]: got %b want 0", i, ctr8); end
        end
    endtask

    task automatic test_and();
        op8 = OP_AND; a8 = 8'hF0; b8 = 8'h3C;
        tick();
        op8 = 4'h0;
        n_cmp++; if (out8 !== 8'h30) begin n_err++; $display("FAIL and_out: got %h want 30", out8); end
        n_cmp++; if (zero8 !== 1'b0) begin n_err++; $display("FAIL and_zero: got %b want 0", zero8); end
        n_cmp++; if (ctr8 !== 1'b1) begin n_err++; $display("FAIL and_ctr: got %b want 1", ctr8); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (ctr8 !== (i < 2)) begin n_err++; $display("FAIL and_hold[%0d]: got %b want %b", i, ctr8, (i < 2)); end
        end
    endtask

    task automatic test_xor_not();
        op8 = OP_XOR; a8 = 8'hA5; b8 = 8'hA5;
        tick();
        op8 = 4'h0;
        n_cmp++; if (out8 !== 8'h00) begin n_err++; $display("FAIL xor_out: got %h want 00", out8); end
        n_cmp++; if (zero8 !== 1'b1) begin n_err++; $display("FAIL xor_zero: got %b want 1", zero8); end
        repeat (3) tick();
        op8 = OP_NOT; a8 = 8'h0F; b8 = 8'($urandom);
        tick();
        op8 = 4'h0;
        n_cmp++; if (out8 !== 8'hF0) begin n_err++; $display("FAIL not_out: got %h want f0", out8); end
        n_cmp++; if (zero8 !== 1'b0) begin n_err++; $display("FAIL not_zero: got %b want 0", zero8); end
        repeat (3) tick();
    endtask

    task automatic test_busy_ignore();
        op8 = OP_AND; a8 = 8'hF0; b8 = 8'h3C;
        tick();
        op8 = OP_OR; a8 = 8'h0F; b8 = 8'h50;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (ctr8 !== (i != 3)) begin n_err++; $display("FAIL busy_ctr[%0d]: got %b want %b", i, ctr8, (i != 3)); end
            n_cmp++;
            if (out8 !== ((i < 4) ? 8'h30 : 8'h5F)) begin
                n_err++; $display("FAIL busy_out[%0d]: got %h want %h", i, out8, (i < 4) ? 8'h30 : 8'h5F);
            end
        end
        op8 = 4'h0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_busy();
        op8 = OP_OR; a8 = 8'h12; b8 = 8'h40;
        tick();
        op8 = 4'h0;
        n_cmp++; if (out8 !== 8'h52) begin n_err++; $display("FAIL or_out: got %h want 52", out8); end
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        n_cmp++; if (ctr8 !== 1'b0) begin n_err++; $display("FAIL midrst_ctr: got %b want 0", ctr8); end
        n_cmp++; if (out8 !== 8'h00) begin n_err++; $display("FAIL midrst_out: got %h want 00", out8); end
        n_cmp++; if (zero8 !== 1'b0) begin n_err++; $display("FAIL midrst_zero: got %b want 0", zero8); end
        op8 = OP_XOR; a8 = 8'h3C; b8 = 8'h0F;
        tick();
        op8 = 4'h0;
        n_cmp++; if (out8 !== 8'h33) begin n_err++; $display("FAIL postrst_out: got %h want 33", out8); end
        n_cmp++; if (ctr8 !== 1'b1) begin n_err++; $display("FAIL postrst_ctr: got %b want 1", ctr8); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ctr8 !== (i < 2)) begin n_err++; $display("FAIL postrst_hold[%0d]: got %b want %b", i, ctr8, (i < 2)); end
        end
    endtask

    task automatic test_random8();
        for (int i = 0; i < 400; i++) begin
            rst8 = ($urandom_range(0, 39) == 0);
            op8  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
            a8   = 8'($urandom);
            b8   = ($urandom_range(0, 4) == 0) ? a8 : 8'($urandom);
            tick();
            n_cmp++; if (out8 !== m8_out) begin n_err++; $display("FAIL rnd8_out[%0d]: got %h want %h", i, out8, m8_out); end
            n_cmp++; if (zero8 !== m8_zero) begin n_err++; $display("FAIL rnd8_zero[%0d]: got %b want %b", i, zero8, m8_zero); end
            n_cmp++; if (ctr8 !== (m8_busy > 0)) begin n_err++; $display("FAIL rnd8_ctr[%0d]: got %b want %b", i, ctr8, (m8_busy > 0)); end
        end
        rst8 = 1'b0; op8 = 4'h0;
        repeat (4) tick();
    endtask

    task automatic test_w16();
        rst16 = 1'b0;
        op16 = OP_NOR; a16 = 16'h0000; b16 = 16'h00FF;
        tick();
        n_cmp++; if (out16 !== 16'hFF00) begin n_err++; $display("FAIL nor16_out: got %h want ff00", out16); end
        n_cmp++; if (zero16 !== 1'b0) begin n_err++; $display("FAIL nor16_zero: got %b want 0", zero16); end
        n_cmp++; if (ctr16 !== 1'b1) begin n_err++; $display("FAIL nor16_ctr: got %b want 1", ctr16); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (ctr16 !== (i % 2 == 0)) begin n_err++; $display("FAIL b2b16_ctr[%0d]: got %b want %b", i, ctr16, (i % 2 == 0)); end
        end
        for (int i = 0; i < 300; i++) begin
            rst16 = ($urandom_range(0, 49) == 0);
            op16  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
            a16   = 16'($urandom);
            b16   = ($urandom_range(0, 4) == 0) ? ~a16 : 16'($urandom);
            tick();
            n_cmp++; if (out16 !== m16_out) begin n_err++; $display("FAIL rnd16_out[%0d]: got %h want %h", i, out16, m16_out); end
            n_cmp++; if (zero16 !== m16_zero) begin n_err++; $display("FAIL rnd16_zero[%0d]: got %b want %b", i, zero16, m16_zero); end
            n_cmp++; if (ctr16 !== (m16_busy > 0)) begin n_err++; $display("FAIL rnd16_ctr[%0d]: got %b want %b", i, ctr16, (m16_busy > 0)); end
        end
    endtask

    initial begin
        m8_out = '0; m8_zero = 1'b0; m8_busy = 0;
        m16_out = '0; m16_zero = 1'b0; m16_busy = 0;
        test_reset();
        test_and();
        test_xor_not();
        test_busy_ignore();
        test_reset_mid_busy();
        test_random8();
        test_w16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
